lfsr_scrambler_par: RTL and testbench

- Parametrised, word-parallel successor to the serial 15-bit LFSR scrambler.
- Processes DATA_W bits per clock through a configurable Fibonacci LFSR (length and taps set by parameters).
- Supports three modes: additive (frame-synchronous), self-synchronising scramble, self-synchronising descramble.
- Valid/ready streaming interface, registered output, seed load and periodic auto-resync. Sits between framing logic and the serialiser/PHY.

---
 rtl/lfsr_scrambler_par_if.sv | 32 +++
 rtl/lfsr_scrambler_par.sv | 111 +++++++++++
 tb/tb_lfsr_scrambler_par.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_scrambler_par_if.sv
// Valid/ready streaming bundle for the word-parallel LFSR scrambler.
// The upstream side drives in_*, the downstream side consumes out_*.
interface lfsr_scrambler_par_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  // Scrambler side: accepts input words, presents output words.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  // Environment side: produces input words, consumes output words.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/lfsr_scrambler_par.sv
// Word-parallel Fibonacci LFSR scrambler/descrambler.
// MODE 0: additive keystream, optional periodic reload of SEED.
// MODE 1: self-synchronising scramble (feeds back the scrambled bit).
// MODE 2: self-synchronising descramble (feeds back the received bit).
// Bit 0 of each word is processed first; all DATA_W steps settle in one cycle.
module lfsr_scrambler_par #(
  parameter int                LFSR_W      = 15,
  parameter logic [LFSR_W-1:0] TAPS        = 15'h6000,
  parameter int                DATA_W      = 8,
  parameter logic [LFSR_W-1:0] SEED        = 15'h7FFF,
  parameter int                MODE        = 0,
  parameter int                SYNC_PERIOD = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed_value,
  lfsr_scrambler_par_if.slave bus,
  output logic [LFSR_W-1:0]   lfsr_out,
  output logic                lockup
);

  localparam bit RESYNC_EN = (MODE == 0) && (SYNC_PERIOD > 0);
  localparam int CNT_W     = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_PERIOD - 1);

  logic [LFSR_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic [LFSR_W-1:0] walk;
  logic [DATA_W-1:0] word_scr;
  logic              tap_bit;
  logic              fb_bit;
  logic              accept;
  logic              resync_hit;

  // Seed load blocks acceptance so a reload never races a state advance.
  assign bus.in_ready  = !seed_load && (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign lfsr_out      = state_q;
  assign lockup        = (MODE == 0) && (state_q == '0);

  assign accept     = bus.in_valid && bus.in_ready;
  assign resync_hit = RESYNC_EN && (cnt_q == CNT_LAST);

  // Unrolled per-bit LFSR walk over the whole input word.
  always_comb begin
    walk     = state_q;
    word_scr = '0;
    tap_bit  = 1'b0;
    fb_bit   = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      tap_bit     = ^(walk & TAPS);
      word_scr[i] = bus.in_data[i] ^ tap_bit;
      case (MODE)
        1:       fb_bit = word_scr[i];
        2:       fb_bit = bus.in_data[i];
        default: fb_bit = tap_bit;
      endcase
      walk = {walk[LFSR_W-2:0], fb_bit};
    end
  end

  // Next-state selection: output holding register, LFSR state, resync counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = word_scr;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (seed_load) begin
      state_d = seed_value;
      cnt_d   = '0;
    end else if (accept) begin
      if (resync_hit) begin
        // The word that completes the period still used the old state.
        state_d = SEED;
        cnt_d   = '0;
      end else begin
        state_d = walk;
        if (RESYNC_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Registers with synchronous reset; reset drops any held output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEED;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_lfsr_scrambler_par.sv
// Directed bench for lfsr_scrambler_par: additive, resync and loopback instances.
module tb_lfsr_scrambler_par;

  logic        clk = 1'b0;
  logic        reset;
  logic        sl0, sl_off;
  logic [14:0] sv0, sv_off;
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  logic [14:0] lo0, lo_sy, lo_s, lo_d;
  logic        lk0, lk_sy, lk_s, lk_d;

  lfsr_scrambler_par_if #(.DATA_W(8)) if0 ();
  lfsr_scrambler_par_if #(.DATA_W(8)) if_sy ();
  lfsr_scrambler_par_if #(.DATA_W(8)) if_s ();
  lfsr_scrambler_par_if #(.DATA_W(8)) if_d ();

  always #5 clk = ~clk;

  lfsr_scrambler_par u0 (
    .clk(clk), .reset(reset), .seed_load(sl0), .seed_value(sv0),
    .bus(if0.slave), .lfsr_out(lo0), .lockup(lk0));

  lfsr_scrambler_par #(.SYNC_PERIOD(4)) u_sy (
    .clk(clk), .reset(reset), .seed_load(sl_off), .seed_value(sv_off),
    .bus(if_sy.slave), .lfsr_out(lo_sy), .lockup(lk_sy));

  lfsr_scrambler_par #(.MODE(1)) u_s (
    .clk(clk), .reset(reset), .seed_load(sl_off), .seed_value(sv_off),
    .bus(if_s.slave), .lfsr_out(lo_s), .lockup(lk_s));

  lfsr_scrambler_par #(.MODE(2), .SEED(15'h1234)) u_d (
    .clk(clk), .reset(reset), .seed_load(sl_off), .seed_value(sv_off),
    .bus(if_d.slave), .lfsr_out(lo_d), .lockup(lk_d));

  // Scrambler output feeds the descrambler directly.
  assign if_d.in_valid  = if_s.out_valid;
  assign if_d.in_data   = if_s.out_data;
  assign if_s.out_ready = if_d.in_ready;

  // Bit-serial reference for PRBS15 (x^15+x^14+1), one word, bit 0 first.
  function automatic void model_word(input int mode, input logic [14:0] st_in,
                                     input logic [7:0] d, output logic [7:0] o,
                                     output logic [14:0] st_out);
    logic [14:0] s;
    logic        f, fb;
    s = st_in;
    o = 8'h00;
    for (int i = 0; i < 8; i++) begin
      f    = s[14] ^ s[13];
      o[i] = d[i] ^ f;
      fb   = (mode == 0) ? f : ((mode == 1) ? o[i] : d[i]);
      s    = {s[13:0], fb};
    end
    st_out = s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b1;
    if0.in_data   = 8'hFF;
    @(negedge clk);
    if0.in_valid = 1'b0;
    chk_cnt++;
    if (if0.out_valid !== 1'b1) $display("FAIL rst_held_word got %b exp 1", if0.out_valid);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_cnt++;
    if (if0.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", if0.out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (if0.out_data !== 8'h00) $display("FAIL rst_out_data got %h exp 00", if0.out_data);
    else pass_cnt++;
    chk_cnt++;
    if (lo0 !== 15'h7FFF) $display("FAIL rst_lfsr_out got %h exp 7fff", lo0);
    else pass_cnt++;
    chk_cnt++;
    if (if0.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", if0.in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (lk0 !== 1'b0) $display("FAIL rst_lockup got %b exp 0", lk0);
    else pass_cnt++;
    if0.out_ready = 1'b1;
  endtask

  task automatic test_additive();
    if0.in_valid = 1'b1;
    if0.in_data  = 8'h00;
    #1;
    chk_cnt++;
    if (if0.out_valid !== 1'b0) $display("FAIL add_pre_valid got %b exp 0", if0.out_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (if0.out_valid !== 1'b1 || if0.out_data !== 8'h00)
      $display("FAIL add_word1 got %b/%h exp 1/00", if0.out_valid, if0.out_data);
    else pass_cnt++;
    @(negedge clk);
    if0.in_valid = 1'b0;
    chk_cnt++;
    if (if0.out_data !== 8'h40) $display("FAIL add_word2 got %h exp 40", if0.out_data);
    else pass_cnt++;
    chk_cnt++;
    if (lo0 !== 15'h0002) $display("FAIL add_state16 got %h exp 0002", lo0);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (if0.out_valid !== 1'b0) $display("FAIL add_drain got %b exp 0", if0.out_valid);
    else pass_cnt++;
  endtask

  // 4100 back-to-back zero words: 32800 keystream bits, enough to see the 32767 period.
  task automatic test_back_to_back();
    bit [0:32799] ks;
    logic [14:0]  m;
    logic [7:0]   exp_o;
    int           gap_err, mod_err, per_err;
    gap_err = 0; mod_err = 0; per_err = 0;
    m = 15'h7FFF;
    do_reset();
    if0.in_valid = 1'b1;
    if0.in_data  = 8'h00;
    for (int n = 0; n < 4100; n++) begin
      @(negedge clk);
      if (if0.out_valid !== 1'b1) gap_err++;
      model_word(0, m, 8'h00, exp_o, m);
      if (if0.out_data !== exp_o) mod_err++;
      for (int b = 0; b < 8; b++) ks[n*8 + b] = if0.out_data[b];
    end
    if0.in_valid = 1'b0;
    for (int j = 0; j + 32767 < 32800; j++) begin
      if (ks[j] !== ks[j + 32767]) per_err++;
    end
    chk_cnt++;
    if (gap_err != 0) $display("FAIL b2b_throughput got %0d bubbles exp 0", gap_err);
    else pass_cnt++;
    chk_cnt++;
    if (mod_err != 0) $display("FAIL b2b_keystream got %0d bad words exp 0", mod_err);
    else pass_cnt++;
    chk_cnt++;
    if (per_err != 0) $display("FAIL b2b_period got %0d differing bits exp 0", per_err);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [14:0] m;
    logic [7:0]  ea, eb, ec;
    do_reset();
    m = 15'h7FFF;
    model_word(0, m, 8'hA5, ea, m);
    model_word(0, m, 8'h3C, eb, m);
    model_word(0, m, 8'h5A, ec, m);
    if0.out_ready = 1'b0;
    if0.in_valid  = 1'b1;
    if0.in_data   = 8'hA5;
    @(negedge clk);
    if0.in_data = 8'h3C;
    #1;
    chk_cnt++;
    if (if0.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", if0.in_ready);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (if0.out_valid !== 1'b1 || if0.out_data !== ea || if0.in_ready !== 1'b0)
        $display("FAIL bp_hold%0d got %b/%h/%b exp 1/%h/0", k, if0.out_valid,
                 if0.out_data, if0.in_ready, ea);
      else pass_cnt++;
    end
    if0.out_ready = 1'b1;
    @(negedge clk);
    if0.in_data = 8'h5A;
    chk_cnt++;
    if (if0.out_data !== eb) $display("FAIL bp_word_b got %h exp %h", if0.out_data, eb);
    else pass_cnt++;
    @(negedge clk);
    if0.in_valid = 1'b0;
    chk_cnt++;
    if (if0.out_data !== ec) $display("FAIL bp_word_c got %h exp %h", if0.out_data, ec);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (if0.out_valid !== 1'b0 || lo0 !== m)
      $display("FAIL bp_end got %b/%h exp 0/%h", if0.out_valid, lo0, m);
    else pass_cnt++;
  endtask

  task automatic test_seed_load();
    do_reset();
    sl0 = 1'b1;
    sv0 = 15'h0000;
    @(negedge clk);
    sl0 = 1'b0;
    chk_cnt++;
    if (lk0 !== 1'b1 || lo0 !== 15'h0000)
      $display("FAIL seed_zero_lockup got %b/%h exp 1/0000", lk0, lo0);
    else pass_cnt++;
    if0.in_valid = 1'b1;
    if0.in_data  = 8'h96;
    @(negedge clk);
    chk_cnt++;
    if (if0.out_data !== 8'h96 || lk0 !== 1'b1)
      $display("FAIL seed_zero_passthru got %h/%b exp 96/1", if0.out_data, lk0);
    else pass_cnt++;
    sl0 = 1'b1;
    sv0 = 15'h7FFF;
    if0.in_data = 8'h11;
    #1;
    chk_cnt++;
    if (if0.in_ready !== 1'b0) $display("FAIL seed_blocks_ready got %b exp 0", if0.in_ready);
    else pass_cnt++;
    @(negedge clk);
    sl0 = 1'b0;
    if0.in_valid = 1'b0;
    chk_cnt++;
    if (lo0 !== 15'h7FFF) $display("FAIL seed_reload got %h exp 7fff", lo0);
    else pass_cnt++;
    chk_cnt++;
    if (if0.out_valid !== 1'b0) $display("FAIL seed_no_accept got %b exp 0", if0.out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (lk0 !== 1'b0) $display("FAIL seed_lockup_clear got %b exp 0", lk0);
    else pass_cnt++;
  endtask

  task automatic test_resync();
    logic [7:0] w [8];
    do_reset();
    if_sy.in_valid = 1'b1;
    if_sy.in_data  = 8'h00;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (n == 7) if_sy.in_valid = 1'b0;
      w[n] = if_sy.out_data;
    end
    chk_cnt++;
    if (w[0] !== 8'h00 || w[1] !== 8'h40)
      $display("FAIL sync_first got %h %h exp 00 40", w[0], w[1]);
    else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      chk_cnt++;
      if (w[k+4] !== w[k]) $display("FAIL sync_repeat%0d got %h exp %h", k, w[k+4], w[k]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (lo_sy !== 15'h7FFF) $display("FAIL sync_state got %h exp 7fff", lo_sy);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [7:0]  iq[$], sq[$], dq[$];
    logic [7:0]  d, exp_o;
    logic [14:0] m;
    int          scr_err, dsc_err;
    scr_err = 0; dsc_err = 0;
    m = 15'h7FFF;
    do_reset();
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (if_s.out_valid) sq.push_back(if_s.out_data);
      if (if_d.out_valid) dq.push_back(if_d.out_data);
      if (c < 64) begin
        d = 8'($urandom);
        if_s.in_valid = 1'b1;
        if_s.in_data  = d;
        iq.push_back(d);
      end else begin
        if_s.in_valid = 1'b0;
      end
    end
    chk_cnt++;
    if (sq.size() != 64 || dq.size() != 64)
      $display("FAIL loop_count got %0d/%0d exp 64/64", sq.size(), dq.size());
    else begin
      pass_cnt++;
      for (int i = 0; i < 64; i++) begin
        model_word(1, m, iq[i], exp_o, m);
        if (sq[i] !== exp_o) scr_err++;
        // Descrambler seed differs; its taps only see real line bits from bit 15 on.
        if (i >= 2 && dq[i] !== iq[i]) dsc_err++;
      end
    end
    chk_cnt++;
    if (scr_err != 0) $display("FAIL loop_scramble got %0d bad words exp 0", scr_err);
    else pass_cnt++;
    chk_cnt++;
    if (dsc_err != 0) $display("FAIL loop_descramble got %0d bad words exp 0", dsc_err);
    else pass_cnt++;
  endtask

  initial begin
    reset  = 1'b1;
    sl0    = 1'b0;
    sv0    = 15'h0000;
    sl_off = 1'b0;
    sv_off = 15'h0000;
    if0.in_valid   = 1'b0; if0.in_data   = 8'h00; if0.out_ready   = 1'b1;
    if_sy.in_valid = 1'b0; if_sy.in_data = 8'h00; if_sy.out_ready = 1'b1;
    if_s.in_valid  = 1'b0; if_s.in_data  = 8'h00;
    if_d.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_additive();
    test_back_to_back();
    test_backpressure();
    test_seed_load();
    test_resync();
    test_loopback();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
